playfield_engine: RTL
=====================

PLAYFIELD_ENGINE -- requirements
Module: playfield_engine

Interface
REQ-001 Parameter PF_BITS, default 22: playfield width in bits, legal range 8..24.
REQ-002 Parameter PIXELS_PER_BIT, default 16: pixels per playfield bit, power of two, 2..64.
REQ-003 Parameter H_START, default 96: first hpos of the image area.
REQ-004 Parameter H_ACTIVE, default 720: width of the image area in pixels.
REQ-005 Port clk, input, 1: single clock; every register in the block uses its rising edge.
REQ-006 Port reset, input, 1: synchronous, active-high reset.
REQ-007 Port enable, input, 1: register-bus read select.
REQ-008 Port write_enable, input, 1: register-bus write strobe.
REQ-009 Port address, input, 6: register address.
REQ-010 Port data_in, input, 8: register write data.
REQ-011 Port data_out, output, 8: registered read data.
REQ-012 Ports hpos and vpos, input, 10 each: video timing position.
REQ-013 Ports in_hblank and in_vblank, input, 1 each: blanking flags.
REQ-014 Ports red, green and blue, output, 8 each: registered pixel colour.
REQ-015 Port irq, output, 1: scanline-compare interrupt.

Function
REQ-016 Writes shall use this map:
- 0x00: PF[7:0] shadow.
- 0x01: PF[15:8] shadow.
- 0x02: PF[23:16] shadow; bits at or above PF_BITS are ignored.
- 0x03: ctrl. bit0 mirror, bit1 immediate, bit2 irq_en.
- 0x04..0x06: fg R/G/B.
- 0x07..0x09: bg R/G/B.
- 0x0a..0x0c: border R/G/B.
- 0x0d: line_cmp[7:0].
- 0x0e: line_cmp[9:8] from data_in[1:0].
- 0x0f: bit0=1 clears irq_pending.
- Any other address: ignored.
REQ-017 A read shall occur when enable=1 and write_enable=0; data_out shall update on the next edge and hold at all other times.
REQ-018 Read addresses 0x00..0x0e shall return the written values, with the playfield reads returning shadow bytes.
REQ-019 Read 0x0f shall return {6'b0, in_vblank, irq_pending} and then clear irq_pending.
REQ-020 Read 0x10 shall return frame_count; reads of unmapped addresses shall return 0.
REQ-021 A rising edge of in_vblank (detected against a registered previous value) shall copy shadow to active playfield and increment the 8-bit frame_count, wrapping 255->0.
REQ-022 A write that coincides with the commit cycle shall land in shadow only; active receives the pre-write shadow.
REQ-023 With immediate=1, playfield writes shall update shadow and active in the same cycle.
REQ-024 Pixel index: x = hpos - H_START, idx = x / PIXELS_PER_BIT.
REQ-025 Normal mode (mirror=0):
- idx < PF_BITS: pixel bit = active[idx].
- idx >= PF_BITS: pixel is border.
REQ-026 Mirror mode (mirror=1):
- idx < PF_BITS: pixel bit = active[idx].
- PF_BITS <= idx < 2*PF_BITS: pixel bit = active[2*PF_BITS-1-idx].
- idx >= 2*PF_BITS: pixel is border.
REQ-027 A pixel bit of 1 shall output fg; a pixel bit of 0 shall output bg.
REQ-028 hpos < H_START or x >= H_ACTIVE shall output border.
REQ-029 When in_hblank or in_vblank is 1, red, green and blue shall be 0; this has priority over all other colour rules.
REQ-030 Colour outputs shall be registered with exactly 1 clk latency from hpos/vpos/blank inputs.
REQ-031 A rising edge of in_hblank with vpos == line_cmp and irq_en=1 shall set irq_pending.
REQ-032 If a set and a clear of irq_pending occur in the same cycle, the set shall win.
REQ-033 irq shall equal irq_pending AND irq_en, registered.

Reset
REQ-034 On reset, the following shall be 0:
- shadow and active playfield.
- ctrl, line_cmp, frame_count, irq_pending, irq.
- data_out, red, green, blue.
- edge-detect registers.
REQ-035 On reset, fg shall become ff/00/00, bg 00/00/ff, and border 00/55/00.
REQ-036 A reset asserted mid-frame shall take effect on the next edge; the following in_vblank rising edge shall commit zeros unless the shadow was rewritten.

Verification
REQ-037 Defaults: after reset, write 0x00=0x01, pulse in_vblank, hpos=96..111 with blanks low -> one cycle later red=ff, green=00, blue=00; hpos=112 -> red=00, green=00, blue=ff.
REQ-038 Shadow: write 0x00=0xff with no vblank edge -> pixel at hpos=96 stays bg; after the in_vblank rise it is fg; a write issued on the commit cycle appears only after the second vblank.
REQ-039 Mirror: PF_BITS=22, PF=22'h000001, ctrl=0x01 -> idx 0 and idx 43 are fg; idx 21 and idx 22 are bg; hpos=95 is border.
REQ-040 IRQ: write ctrl=0x04, line_cmp=0x10A, then in_hblank rise at vpos=266 -> irq=1; read 0x0f returns 0x01 and irq drops; simultaneous clear and set leaves irq=1.
REQ-041 Frame counter: 256 in_vblank rises -> read 0x10 returns 0x00; 257 rises -> read returns 0x01.

Source files
------------

// File: rtl/playfield_engine.sv
// Playfield engine: double-buffered playfield bitmap with optional
// mirroring, register bus, frame counter and scanline-compare interrupt.
module playfield_engine #(
    parameter int PF_BITS        = 22,
    parameter int PIXELS_PER_BIT = 16,
    parameter int H_START        = 96,
    parameter int H_ACTIVE       = 720
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic       write_enable,
    input  logic [5:0] address,
    input  logic [7:0] data_in,
    output logic [7:0] data_out,
    input  logic [9:0] hpos,
    input  logic [9:0] vpos,
    input  logic       in_hblank,
    input  logic       in_vblank,
    output logic [7:0] red,
    output logic [7:0] green,
    output logic [7:0] blue,
    output logic       irq
);

    localparam int          SHIFT   = $clog2(PIXELS_PER_BIT);
    localparam logic [31:0] MASK32  = (32'd1 << PF_BITS) - 32'd1;
    localparam logic [23:0] PF_MASK = MASK32[23:0];
    localparam logic [10:0] HS      = 11'(H_START);
    localparam logic [10:0] HA      = 11'(H_ACTIVE);
    localparam logic [10:0] PFB     = 11'(PF_BITS);
    localparam logic [10:0] PF2     = 11'(2 * PF_BITS);

    logic [23:0] shadow, active, shadow_next;
    logic [2:0]  ctrl;
    logic [7:0]  col [9];
    logic [9:0]  line_cmp;
    logic [7:0]  frame_count;
    logic        irq_pending, vblank_q, hblank_q;
    logic        rd_en, wr_pf, commit, irq_set, irq_clr;
    logic [7:0]  rd_data;
    logic [10:0] x, idx;
    logic [4:0]  midx;
    logic        in_area;
    logic [23:0] pix_col, fg, bg, border;

    assign fg     = {col[0], col[1], col[2]};
    assign bg     = {col[3], col[4], col[5]};
    assign border = {col[6], col[7], col[8]};

    // Bus decode, vblank commit / hblank irq edges, next shadow value
    always_comb begin
        rd_en       = enable & ~write_enable;
        wr_pf       = write_enable && (address <= 6'h02);
        commit      = in_vblank & ~vblank_q;
        irq_set     = in_hblank & ~hblank_q & (vpos == line_cmp) & ctrl[2];
        irq_clr     = (write_enable && address == 6'h0f && data_in[0])
                    || (rd_en && address == 6'h0f);
        shadow_next = shadow;
        if (write_enable) begin
            case (address)
                6'h00: shadow_next[7:0]   = data_in;
                6'h01: shadow_next[15:8]  = data_in;
                6'h02: shadow_next[23:16] = data_in & PF_MASK[23:16];
                default: ;
            endcase
        end
    end

    // Read-back multiplexer
    always_comb begin
        rd_data = '0;
        if (address inside {[6'h04:6'h0c]}) begin
            rd_data = col[4'(address - 6'd4)];
        end else begin
            case (address)
                6'h00: rd_data = shadow[7:0];
                6'h01: rd_data = shadow[15:8];
                6'h02: rd_data = shadow[23:16];
                6'h03: rd_data = {5'b0, ctrl};
                6'h0d: rd_data = line_cmp[7:0];
                6'h0e: rd_data = {6'b0, line_cmp[9:8]};
                6'h0f: rd_data = {6'b0, in_vblank, irq_pending};
                6'h10: rd_data = frame_count;
                default: rd_data = '0;
            endcase
        end
    end

    // Pixel colour selection; blanking overrides everything
    always_comb begin
        x       = {1'b0, hpos} - HS;
        in_area = ({1'b0, hpos} >= HS) && (x < HA);
        idx     = x >> SHIFT;
        midx    = 5'(PF2 - 11'd1 - idx);
        pix_col = border;
        if (in_hblank || in_vblank) begin
            pix_col = '0;
        end else if (!in_area) begin
            pix_col = border;
        end else if (idx < PFB) begin
            pix_col = active[idx[4:0]] ? fg : bg;
        end else if (ctrl[0] && idx < PF2) begin
            pix_col = active[midx] ? fg : bg;
        end
    end

    // Register file, playfield buffers, frame counter and interrupt state
    always_ff @(posedge clk) begin
        if (reset) begin
            shadow      <= '0;
            active      <= '0;
            ctrl        <= '0;
            line_cmp    <= '0;
            frame_count <= '0;
            irq_pending <= 1'b0;
            irq         <= 1'b0;
            data_out    <= '0;
            vblank_q    <= 1'b0;
            hblank_q    <= 1'b0;
            for (int i = 0; i < 9; i++) col[i] <= 8'h00;
            col[0] <= 8'hff;
            col[5] <= 8'hff;
            col[7] <= 8'h55;
        end else begin
            vblank_q <= in_vblank;
            hblank_q <= in_hblank;
            shadow   <= shadow_next;
            if (commit) begin
                active      <= shadow;
                frame_count <= frame_count + 8'd1;
            end
            if (wr_pf && ctrl[1]) active <= shadow_next;
            if (write_enable) begin
                if (address inside {[6'h04:6'h0c]}) begin
                    col[4'(address - 6'd4)] <= data_in;
                end else begin
                    case (address)
                        6'h03: ctrl          <= data_in[2:0];
                        6'h0d: line_cmp[7:0] <= data_in;
                        6'h0e: line_cmp[9:8] <= data_in[1:0];
                        default: ;
                    endcase
                end
            end
            irq_pending <= irq_set | (irq_pending & ~irq_clr);
            irq         <= irq_pending & ctrl[2];
            if (rd_en) data_out <= rd_data;
        end
    end

    // Registered colour output, one clock after the timing inputs
    always_ff @(posedge clk) begin
        if (reset) begin
            red   <= '0;
            green <= '0;
            blue  <= '0;
        end else begin
            {red, green, blue} <= pix_col;
        end
    end

endmodule
